// File: rtl/decoder_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
// State encoding and requester geometry live here so every file agrees.
package decoder_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_arbiter_decoder.sv
// 3-to-8 decoder with enable; Out is one-hot on In when E is high.
// Used by the arbiter to turn its registered select into a grant vector.
module decoder
    import decoder_arbiter_pkg::*;
(
    input  logic               E,
    input  logic [SEL_W-1:0]   In,
    output logic [NUM_REQ-1:0] Out
);

    always_comb begin
        Out = '0;
        if (E) begin
            Out[In] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing a 3-to-8 decoder among eight requesters.
// Ownership lasts until release or hold timeout, then one dead cycle.
module decoder_arbiter
    import decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               dec_E,
    output logic [SEL_W-1:0]   dec_In,
    output logic [NUM_REQ-1:0] grant,
    output logic               timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    arb_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  last_idx;

    logic              found;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  cand;

    // Search starts just after the previous owner, so it ranks last.
    always_comb begin
        found  = 1'b0;
        winner = last_idx;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_idx + SEL_W'(i);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            dec_E    <= 1'b0;
            dec_In   <= '0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_idx <= SEL_W'(NUM_REQ - 1);
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    hold_cnt <= '0;
                    if (found) begin
                        state  <= GRANT;
                        dec_E  <= 1'b1;
                        dec_In <= winner;
                    end else begin
                        state <= IDLE;
                        dec_E <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[dec_In]) begin
                        state    <= GAP;
                        dec_E    <= 1'b0;
                        last_idx <= dec_In;
                        hold_cnt <= '0;
                    end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
                        state    <= GAP;
                        dec_E    <= 1'b0;
                        last_idx <= dec_In;
                        hold_cnt <= '0;
                        timeout  <= 1'b1;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dec_E <= 1'b0;
                end
            endcase
        end
    end

    decoder decoder_1 (
        .E   (dec_E),
        .In  (dec_In),
        .Out (grant)
    );

endmodule

// File: tb/tb_decoder_arbiter.sv
// Scoreboard bench for decoder_arbiter across MAX_HOLD = 16, 4 and 0.
// Each step pushes stimulus plus expected grant/timeout, then compares.
module tb_decoder_arbiter;

    typedef struct {
        logic       rn;
        logic [7:0] r;
        logic [7:0] g;
        logic [2:0] idx;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;

    logic       e16, e4, e0;
    logic [2:0] in16, in4, in0;
    logic [7:0] g16, g4, g0;
    logic       to16, to4, to0;

    logic [1:0] sel = 2'd0;
    logic       obs_e;
    logic [2:0] obs_in;
    logic [7:0] obs_g;
    logic       obs_to;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    decoder_arbiter #(.MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dec_E(e16), .dec_In(in16), .grant(g16), .timeout(to16)
    );

    decoder_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dec_E(e4), .dec_In(in4), .grant(g4), .timeout(to4)
    );

    decoder_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .dec_E(e0), .dec_In(in0), .grant(g0), .timeout(to0)
    );

    always_comb begin
        obs_e  = e16;
        obs_in = in16;
        obs_g  = g16;
        obs_to = to16;
        if (sel == 2'd1) begin
            obs_e = e4; obs_in = in4; obs_g = g4; obs_to = to4;
        end else if (sel == 2'd2) begin
            obs_e = e0; obs_in = in0; obs_g = g0; obs_to = to0;
        end
    end

    task automatic push(input logic rn, input logic [7:0] r,
                        input logic [7:0] g, input logic to);
        exp_t e;
        e.rn = rn; e.r = r; e.g = g; e.to = to; e.idx = '0;
        for (int b = 0; b < 8; b++)
            if (g[b]) e.idx = 3'(b);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (g16 !== 8'h00 || g4 !== 8'h00 || g0 !== 8'h00 ||
                e16 !== 1'b0 || e4 !== 1'b0 || e0 !== 1'b0 ||
                to16 !== 1'b0 || to4 !== 1'b0 || to0 !== 1'b0)
                $display("FAIL reset cyc %0d: grant=%h/%h/%h dec_E=%b%b%b timeout=%b%b%b, need grant=00 dec_E=0 timeout=0",
                         c, g16, g4, g0, e16, e4, e0, to16, to4, to0);
            else passed++;
        end
        rst_n = 1'b1;
        req = 8'h00;
    endtask

    task automatic test_single();
        exp_t e;
        int   s = 0;
        sel = 2'd0;
        for (int c = 0; c < 3; c++) push(1, 8'h04, 8'h04, 0);
        push(1, 8'h00, 8'h00, 0);
        push(1, 8'h00, 8'h00, 0);
        push(1, 8'h00, 8'h00, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rn; req = e.r;
            @(posedge clk); #1;
            total++;
            if (obs_g !== e.g || obs_to !== e.to || obs_e !== (e.g != 0) ||
                (e.g != 0 && obs_in !== e.idx))
                $display("FAIL single step %0d: grant=%h dec_E=%b dec_In=%0d timeout=%b, need grant=%h dec_In=%0d timeout=%b",
                         s, obs_g, obs_e, obs_in, obs_to, e.g, e.idx, e.to);
            else passed++;
            s++;
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        int   s = 0;
        sel = 2'd1;
        push(0, 8'h00, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++)
                push(1, 8'hFF, 8'(1 << (k % 8)), 0);
            if (k < 8) push(1, 8'hFF, 8'h00, 1);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rn; req = e.r;
            @(posedge clk); #1;
            total++;
            if (obs_g !== e.g || obs_to !== e.to || obs_e !== (e.g != 0) ||
                (e.g != 0 && obs_in !== e.idx))
                $display("FAIL rotation step %0d: grant=%h dec_E=%b dec_In=%0d timeout=%b, need grant=%h dec_In=%0d timeout=%b",
                         s, obs_g, obs_e, obs_in, obs_to, e.g, e.idx, e.to);
            else passed++;
            s++;
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   s = 0;
        sel = 2'd0;
        push(0, 8'h00, 8'h00, 0);
        push(1, 8'h40, 8'h40, 0);
        push(1, 8'h40, 8'h40, 0);
        push(1, 8'h01, 8'h00, 0);
        push(1, 8'h41, 8'h01, 0);
        push(1, 8'h41, 8'h01, 0);
        push(1, 8'hC0, 8'h00, 0);
        push(1, 8'hC0, 8'h40, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rn; req = e.r;
            @(posedge clk); #1;
            total++;
            if (obs_g !== e.g || obs_to !== e.to || obs_e !== (e.g != 0) ||
                (e.g != 0 && obs_in !== e.idx))
                $display("FAIL wrap step %0d: grant=%h dec_E=%b dec_In=%0d timeout=%b, need grant=%h dec_In=%0d timeout=%b",
                         s, obs_g, obs_e, obs_in, obs_to, e.g, e.idx, e.to);
            else passed++;
            s++;
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   s = 0;
        sel = 2'd1;
        push(0, 8'h00, 8'h00, 0);
        for (int c = 0; c < 4; c++) push(1, 8'h20, 8'h20, 0);
        push(0, 8'h20, 8'h00, 0);
        push(1, 8'h21, 8'h01, 0);
        push(1, 8'h21, 8'h01, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rn; req = e.r;
            @(posedge clk); #1;
            total++;
            if (obs_g !== e.g || obs_to !== e.to || obs_e !== (e.g != 0) ||
                (e.g != 0 && obs_in !== e.idx))
                $display("FAIL mid_reset step %0d: grant=%h dec_E=%b dec_In=%0d timeout=%b, need grant=%h dec_In=%0d timeout=%b",
                         s, obs_g, obs_e, obs_in, obs_to, e.g, e.idx, e.to);
            else passed++;
            s++;
        end
    endtask

    task automatic test_no_timeout();
        exp_t e;
        int   s = 0;
        sel = 2'd2;
        push(0, 8'h00, 8'h00, 0);
        for (int c = 0; c < 300; c++) push(1, 8'h08, 8'h08, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rst_n = e.rn; req = e.r;
            @(posedge clk); #1;
            total++;
            if (obs_g !== e.g || obs_to !== e.to || obs_e !== (e.g != 0) ||
                (e.g != 0 && obs_in !== e.idx))
                $display("FAIL no_timeout step %0d: grant=%h dec_E=%b dec_In=%0d timeout=%b, need grant=%h dec_In=%0d timeout=%b",
                         s, obs_g, obs_e, obs_in, obs_to, e.g, e.idx, e.to);
            else passed++;
            s++;
        end
        total++;
        if (dut0.hold_cnt !== 8'hFF)
            $display("FAIL hold_sat: hold_cnt=%0d, need 255", dut0.hold_cnt);
        else passed++;
        req = 8'h00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_mid_reset();
        test_no_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decoder_arbiter.md
Name: decoder_arbiter

Overview:
Round-robin arbiter that shares the 3-to-8 decoder among 8 requesters. It drives the decoder's enable and select inputs from registers, so the decoder output is a one-hot grant vector. The block sits between the request sources and any resource selected through the decoder, such as chip selects or an LED/digit enable bank. Ownership is held until release or until a hold timeout, with a mandatory dead cycle between owners.

Parameters:
NUM_REQ, 8, number of requesters; fixed to 8 (decoder width); other values are unsupported.
SEL_W, 3, select width; equals log2(NUM_REQ).
MAX_HOLD, 16, maximum grant cycles per ownership; 0 disables the timeout; legal range 0..255.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  reset; synchronous, active-low.
req  input  8  request vector; bit i high = requester i wants or keeps ownership.
dec_E  output  1  registered enable driven to the decoder.
dec_In  output  3  registered select driven to the decoder (owner index).
grant  output  8  decoder Out; one-hot owner when dec_E=1, else 8'h00.
timeout  output  1  one-cycle pulse when an owner is forcibly revoked.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n). Reset is sampled only on a clk rising edge.
- Reset values:
  - state = IDLE; dec_E = 0; dec_In = 3'b000; grant = 8'h00; timeout = 0.
  - hold_cnt = 0; last_idx = 3'd7, so requester 0 has first priority after reset.
- States: IDLE, GRANT, GAP.
- Arbitration (in IDLE and GAP): at a clock edge where req != 0, pick the first set bit searching last_idx+1, last_idx+2, ..., modulo 8 (wrap 7->0).
  - Next state = GRANT; dec_E = 1; dec_In = winner; hold_cnt = 0.
  - If req = 0, the next state is IDLE.
- Latency: request sampled at edge k -> grant valid right after edge k (1 cycle).
- grant is combinational decode of the registered dec_E/dec_In only. No combinational path from req to grant.
- GRANT, owner idx = dec_In:
  - Release: req[idx] = 0 at an edge -> GAP. dec_E = 0, last_idx = idx, hold_cnt = 0.
  - Timeout: MAX_HOLD != 0, req[idx] = 1 and hold_cnt == MAX_HOLD-1 -> GAP. dec_E = 0, last_idx = idx, timeout = 1 for exactly the following cycle.
  - Otherwise: stay in GRANT, hold_cnt += 1. hold_cnt is 8-bit and saturates at 255 when MAX_HOLD = 0.
  - An owner therefore holds the grant at most MAX_HOLD cycles.
- GAP:
  - Lasts exactly one cycle with grant = 8'h00 (break-before-make).
  - Arbitrates at its closing edge exactly like IDLE.
  - The previous owner has the lowest priority.
- Other req bits changing during GRANT have no effect until the next arbitration.
- Simultaneous release and timeout at the same edge: counts as release, so timeout stays 0.
- dec_In holds its last value while dec_E = 0. The bench must not check dec_In when dec_E = 0.
- Reset mid-operation: at the first edge with rst_n = 0, all reset values apply regardless of state.
  - No timeout pulse is generated.
  - Priority returns to requester 0.
- Invariant: popcount(grant) <= 1 at all times; grant != 0 only in GRANT.

Decomposition:
- Shared package: state encoding (IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2) and the NUM_REQ/SEL_W constants.
- Sub-module: instantiate the existing decoder module (ports E, In, Out) as decoder_1, driven by dec_E/dec_In. Its Out drives grant.
- The round-robin priority search stays inline as a combinational loop. No further sub-modules.

Test Plan:
1. Reset: rst_n = 0 for 3 cycles with req = 8'hFF -> grant = 8'h00, dec_E = 0, timeout = 0 every cycle.
2. Single request:
   - req = 8'h04 from cycle 1 -> from the next edge grant = 8'h04, dec_In = 3'b010.
   - Drop req after 3 grant cycles -> grant = 8'h00 for 1 cycle, then IDLE; timeout never asserts.
3. Rotation under timeout: MAX_HOLD = 4, req = 8'hFF held.
   - grant sequence 8'h01, 8'h02, ..., 8'h80, 8'h01: each grant 4 cycles, followed by 1 zero cycle.
   - One timeout pulse per revocation.
4. Wrap priority:
   - Let requester 6 own, then release, with req = 8'h41 -> next grant = 8'h01 (order 7, 0 before 6).
   - Then req = 8'hC0 after 0 releases -> grant = 8'h40.
5. Reset mid-grant:
   - Requester 5 owns (grant = 8'h20); rst_n = 0 for 1 cycle -> grant = 8'h00, no timeout.
   - Then req = 8'h21 -> grant = 8'h01.
6. Timeout disabled: MAX_HOLD = 0, req = 8'h08 held 300 cycles -> grant = 8'h08 throughout, timeout = 0, hold_cnt saturates without wrap.
